// File: rtl/connect_four_pkg.sv
// Shared types and default geometry for the LED-matrix row scanner.
package connect_four_pkg;
    localparam int NUM_ROWS = 16;
    localparam int ROW_W    = 16;
    localparam int DWELL    = 32;

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, HOLD} scan_state_t;
endpackage

// File: rtl/circ_shift_reg.sv
// Circular load/rotate shift register; MSB is the serial output.
module circ_shift_reg #(
    parameter int WIDTH = connect_four_pkg::ROW_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);
    logic [WIDTH-1:0] r_data;

    // Rotating left keeps the row intact: after WIDTH shifts it holds the loaded value.
    always_ff @(posedge clock) begin
        if (reset)
            r_data <= '0;
        else if (load)
            r_data <= din;
        else
            r_data <= {r_data[WIDTH-2:0], r_data[WIDTH-1]};
    end

    assign dout = r_data[WIDTH-1];
endmodule

// File: rtl/row_scan_controller.sv
// Row sequencer: load a row into the shift register, stream it MSB-first,
// latch, dwell, then advance row_sel (wrapping) and optionally continue.
module row_scan_controller #(
    parameter int NUM_ROWS = connect_four_pkg::NUM_ROWS,
    parameter int ROW_W    = connect_four_pkg::ROW_W,
    parameter int DWELL    = connect_four_pkg::DWELL
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        sr_out,
    output logic [$clog2(NUM_ROWS)-1:0] row_sel,
    output logic                        sr_load,
    output logic                        ser_bit,
    output logic                        ser_valid,
    output logic                        latch,
    output logic                        frame_done,
    output logic                        busy
);
    import connect_four_pkg::*;

    localparam int RS_W = $clog2(NUM_ROWS);
    localparam int BC_W = (ROW_W > 1) ? $clog2(ROW_W) : 1;
    localparam int DC_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    scan_state_t     r_state;
    scan_state_t     w_state_nxt;
    logic [BC_W-1:0] r_bit_cnt;
    logic [DC_W-1:0] r_dwell_cnt;
    logic [RS_W-1:0] r_row_sel;
    logic            r_frame_done;

    logic w_bit_last;
    logic w_dwell_last;
    logic w_row_last;

    assign w_bit_last   = (r_bit_cnt == BC_W'(ROW_W - 1));
    assign w_dwell_last = (r_dwell_cnt == DC_W'(DWELL - 1));
    assign w_row_last   = (r_row_sel == RS_W'(NUM_ROWS - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_bit_cnt    <= '0;
            r_dwell_cnt  <= '0;
            r_row_sel    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= 1'b0;
            case (r_state)
                LOAD:  r_bit_cnt <= '0;
                SHIFT: r_bit_cnt <= r_bit_cnt + 1'b1;
                LATCH: r_dwell_cnt <= '0;
                HOLD: begin
                    r_dwell_cnt <= r_dwell_cnt + 1'b1;
                    // row_sel only moves here, so it is stable for the whole row.
                    if (w_dwell_last) begin
                        r_row_sel    <= w_row_last ? '0 : r_row_sel + 1'b1;
                        r_frame_done <= w_row_last;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        sr_load     = 1'b0;
        ser_valid   = 1'b0;
        latch       = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (enable) w_state_nxt = LOAD;
            end
            LOAD: begin
                sr_load     = 1'b1;
                w_state_nxt = SHIFT;
            end
            SHIFT: begin
                ser_valid = 1'b1;
                if (w_bit_last) w_state_nxt = LATCH;
            end
            LATCH: begin
                latch       = 1'b1;
                w_state_nxt = HOLD;
            end
            HOLD: begin
                if (w_dwell_last) w_state_nxt = enable ? LOAD : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign row_sel    = r_row_sel;
    assign frame_done = r_frame_done;
    assign ser_bit    = sr_out;
endmodule

// File: tb/tb_row_scan_controller.sv
// Randomised scoreboard bench for row_scan_controller with the real shift register.
module tb_row_scan_controller;
    import connect_four_pkg::*;

    localparam int NR = 16;
    localparam int RW = 16;
    localparam int DW = 32;
    localparam int ROW_PERIOD = 1 + RW + 1 + DW;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b1;
    logic sr_out, sr_load, ser_bit, ser_valid, latch, frame_done, busy;
    logic [3:0] row_sel;
    logic [RW-1:0] rom [NR];
    logic [RW-1:0] row_data;

    assign row_data = rom[row_sel];
    always #5 clock = ~clock;

    row_scan_controller #(.NUM_ROWS(NR), .ROW_W(RW), .DWELL(DW)) dut (
        .clock(clock), .reset(reset), .enable(enable), .sr_out(sr_out),
        .row_sel(row_sel), .sr_load(sr_load), .ser_bit(ser_bit),
        .ser_valid(ser_valid), .latch(latch), .frame_done(frame_done), .busy(busy)
    );

    circ_shift_reg #(.WIDTH(RW)) u_sr (
        .clock(clock), .reset(reset), .load(sr_load), .din(row_data), .dout(sr_out)
    );

    typedef struct {
        int            row;
        logic [RW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: a timeline of row_sel / frame_done derived from latch times,
    // plus a queue of rows whose serial bits are still owed.
    int m_sel = 0, adv_cyc = -1, fd_cyc = -1;
    int last_load = -1, last_fd = -1;
    int cnt = 0, loads = 0, frames = 0;
    logic [RW-1:0] bits = '0;
    logic prev_valid = 1'b0, prev_reset = 1'b1;

    always @(posedge clock) begin
        exp_t e;
        #1;
        cyc++;
        if (reset) begin
            chk("reset_outputs", {row_sel, sr_load, ser_valid, latch, frame_done, busy}, 0);
            exp_q.delete();
            m_sel = 0; adv_cyc = -1; fd_cyc = -1; last_load = -1; last_fd = -1;
            cnt = 0; prev_valid = 1'b0; prev_reset = 1'b1;
        end else begin
            if (cyc == adv_cyc) begin
                m_sel = (m_sel + 1) % NR;
                adv_cyc = -1;
            end
            chk("row_sel", row_sel, m_sel);
            chk("inv_load_and_valid", sr_load & ser_valid, 0);
            chk("inv_latch_and_valid", latch & ser_valid, 0);
            chk("inv_busy_state", busy, dut.r_state != IDLE);
            chk("ser_bit_passthru", ser_bit, sr_out);
            if (prev_reset) chk("load_after_reset", sr_load, enable);
            prev_reset = 1'b0;
            if (frame_done || cyc == fd_cyc) begin
                chk("frame_done", frame_done, cyc == fd_cyc);
                if (frame_done) begin
                    frames++;
                    if (last_fd >= 0) chk("frame_period", cyc - last_fd, NR * ROW_PERIOD);
                    last_fd = cyc;
                end
            end
            if (sr_load) begin
                loads++;
                if (last_load >= 0) chk("load_period", cyc - last_load, ROW_PERIOD);
                last_load = cyc;
                e.row = m_sel;
                e.data = rom[m_sel];
                exp_q.push_back(e);
                cnt = 0;
            end
            if (ser_valid) begin
                if (cnt == 0) chk("load_to_bit0", cyc - last_load, 1);
                if (cnt >= RW) chk("valid_overrun", cnt, RW - 1);
                bits = {bits[RW-2:0], ser_bit};
                cnt++;
            end
            if (latch) begin
                chk("bit_count", cnt, RW);
                chk("latch_after_last_bit", prev_valid, 1);
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL latch_without_row: got latch expected none (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("row_bits", bits, e.data);
                    chk("latch_row", row_sel, e.row);
                    adv_cyc = cyc + 1 + DW;
                    if (e.row == NR - 1) fd_cyc = cyc + 1 + DW;
                end
                cnt = 0;
            end
            if (!busy) begin
                last_load = -1;
                last_fd = -1;
            end
            prev_valid = ser_valid;
        end
    end

    initial begin
        int t, f0, l0;
        for (int i = 0; i < NR; i++) rom[i] = RW'($urandom);
        rom[0] = 16'h3380;
        reset = 1'b1; enable = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Two full frames of continuous scan.
        f0 = frames; t = 0;
        while (frames < f0 + 2 && t < 2000) begin @(negedge clock); t++; end
        chk("two_frames_seen", frames >= f0 + 2, 1);

        // Stop mid-SHIFT of row 5: row completes, then idle at row 6.
        t = 0;
        while (!(sr_load && row_sel == 4'd5) && t < 1000) begin @(negedge clock); t++; end
        chk("reach_row5", sr_load && row_sel == 4'd5, 1);
        repeat (4) @(negedge clock);
        enable = 1'b0;
        t = 0;
        while (busy && t < 100) begin @(negedge clock); t++; end
        chk("stop_idle", busy, 0);
        chk("stop_row_sel", row_sel, 6);
        chk("stop_row5_drained", exp_q.size(), 0);
        l0 = loads;
        repeat (10) @(negedge clock);
        chk("idle_no_load", loads, l0);
        enable = 1'b1;
        t = 0;
        while (!sr_load && t < 5) begin @(negedge clock); t++; end
        chk("restart_row6", {sr_load, row_sel}, {1'b1, 4'd6});

        // Random enable toggling.
        for (int it = 0; it < 8; it++) begin
            repeat ($urandom_range(20, 200)) @(negedge clock);
            enable = 1'b0;
            repeat ($urandom_range(1, 80)) @(negedge clock);
            enable = 1'b1;
        end

        // Reset during SHIFT bit 7.
        t = 0;
        while (!sr_load && t < 200) begin @(negedge clock); t++; end
        chk("reach_load", sr_load, 1);
        repeat (8) @(negedge clock);
        chk("bit7_valid", ser_valid, 1);
        reset = 1'b1;
        @(negedge clock);
        chk("midreset_outs", {row_sel, ser_valid, latch, busy}, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (300) @(negedge clock);

        enable = 1'b0;
        t = 0;
        while (busy && t < 100) begin @(negedge clock); t++; end
        chk("final_idle", busy, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
